// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: pointer/flag controller wrapping a dual-port bram as a
// synchronous FIFO. Drives the bram ports combinationally from the current
// pointers and forwards the bram's registered read data with a valid strobe.
module bram_fifo_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] mem_addr_in,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic            rd_valid_q, rd_valid_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push_acc, pop_acc;

  // Flags and occupancy derived purely from the registered pointers.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
            (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
    count = wptr_q - rptr_q;
  end

  // Accept decisions use pre-edge state only; reset blocks both sides so
  // the bram sees no write or read while rst is high.
  always_comb begin
    push_acc = push & ~full  & ~rst;
    pop_acc  = pop  & ~empty & ~rst;
  end

  // Bram drive and read-data pass-through.
  always_comb begin
    mem_wr_en    = push_acc;
    mem_addr_in  = wptr_q[ADDR_W-1:0];
    mem_data_in  = push_data;
    mem_rd_en    = pop_acc;
    mem_addr_out = rptr_q[ADDR_W-1:0];
    rd_data      = mem_data_out;
    rd_valid     = rd_valid_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

  // Next-state: advance pointers on acceptance, latch sticky errors on
  // rejection. rd_valid tracks the bram's one-cycle read latency.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = pop_acc;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (push_acc) wptr_d = wptr_q + 1'b1;
    if (pop_acc)  rptr_d = rptr_q + 1'b1;
    if (push && full && !rst)  ovf_d = 1'b1;
    if (pop  && empty && !rst) unf_d = 1'b1;
  end

  // State registers with synchronous active-high reset; bram contents are
  // left alone, the pointer reset makes old data unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: scoreboard bench for bram_fifo_ctrl with a behavioural
// dual-port bram (registered read, one-cycle latency) attached.
module tb_bram_fifo_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, push, pop;
  logic [DATA_W-1:0] push_data;
  logic              full, empty, rd_valid, overflow, underflow;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rd_data, mem_data_in, mem_data_out;
  logic [ADDR_W-1:0] mem_addr_in, mem_addr_out;
  logic              mem_wr_en, mem_rd_en;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .full(full), .empty(empty), .count(count), .rd_valid(rd_valid),
    .rd_data(rd_data), .overflow(overflow), .underflow(underflow),
    .mem_addr_in(mem_addr_in), .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in),
    .mem_addr_out(mem_addr_out), .mem_rd_en(mem_rd_en), .mem_data_out(mem_data_out)
  );

  // Behavioural bram: write port and registered read port.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr_in] <= mem_data_in;
    if (mem_rd_en) mem_data_out <= mem[mem_addr_out];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [DATA_W-1:0] data_q[$];   // words held in the FIFO
  logic [DATA_W-1:0] exp_q[$];    // words popped, awaiting rd_valid
  int mw = 0, mr = 0, mcnt = 0;
  bit m_vld = 0, m_ovf = 0, m_unf = 0;

  // One clock cycle: drive just after the edge, check mid-cycle, update model.
  task automatic step(input bit p, input logic [DATA_W-1:0] d, input bit q, input bit r);
    bit pa, qa;
    push = p; push_data = d; pop = q; rst = r;
    pa = p && !r && (mcnt < DEPTH);
    qa = q && !r && (mcnt > 0);
    @(negedge clk);
    chk("wr_en", 32'(mem_wr_en), 32'(pa));
    chk("rd_en", 32'(mem_rd_en), 32'(qa));
    if (pa) begin
      chk("addr_in", 32'(mem_addr_in), 32'(mw % DEPTH));
      chk("data_in", 32'(mem_data_in), 32'(d));
    end
    if (qa) chk("addr_out", 32'(mem_addr_out), 32'(mr % DEPTH));
    chk("count", 32'(count), 32'(mcnt));
    chk("full", 32'(full), 32'(mcnt == DEPTH));
    chk("empty", 32'(empty), 32'(mcnt == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("rd_valid", 32'(rd_valid), 32'(m_vld));
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("rd_extra", 32'(rd_data), 32'hFFFF_FFFF);
      else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
    if (r) begin
      mw = 0; mr = 0; mcnt = 0; m_vld = 0; m_ovf = 0; m_unf = 0;
      data_q.delete(); exp_q.delete();
    end else begin
      if (p && !pa) m_ovf = 1;
      if (q && !qa) m_unf = 1;
      if (pa) begin data_q.push_back(d); mw = (mw + 1) % (2 * DEPTH); mcnt++; end
      if (qa) begin exp_q.push_back(data_q.pop_front()); mr = (mr + 1) % (2 * DEPTH); mcnt--; end
      m_vld = qa;
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    @(posedge clk); #1;
    step(0, 8'h00, 0, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);

    // Three pushes then three pops.
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    chk("tp_count3", 32'(count), 32'd3);
    chk("tp_notempty", 32'(empty), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("tp_count0", 32'(count), 32'd0);
    chk("tp_empty", 32'(empty), 32'd1);

    // Fill to full, then one rejected push.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd256);
    step(1, 8'h55, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd256);
    // Full with push+pop: pop wins, count drops by one.
    step(1, 8'h66, 1, 0);
    chk("full_pp_count", 32'(count), 32'd255);

    // Drain, then underflow cases.
    for (int i = 0; i < DEPTH - 1; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("unf_set", 32'(underflow), 32'd1);
    step(0, 8'h00, 0, 0);
    step(1, 8'h77, 1, 0);
    chk("empty_pp_count", 32'(count), 32'd1);
    chk("empty_pp_unf", 32'(underflow), 32'd1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Clear flags, prime, then 600 cycles of push+pop across pointer wraps.
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 600; i++) step(1, 8'($urandom_range(0, 255)), 1, 0);
    chk("stream_count", 32'(count), 32'd4);
    chk("stream_ovf", 32'(overflow), 32'd0);
    chk("stream_unf", 32'(underflow), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Reset right after a pop with count = 5.
    for (int i = 0; i < 6; i++) step(1, 8'(8'h10 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    chk("pre_rst_count", 32'(count), 32'd5);
    step(0, 8'h00, 0, 1);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_vld", 32'(rd_valid), 32'd0);
    chk("post_rst_ovf", 32'(overflow), 32'd0);
    chk("post_rst_unf", 32'(underflow), 32'd0);
    step(1, 8'hAA, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("aa_valid", 32'(rd_valid), 32'd1);
    chk("aa_data", 32'(rd_data), 32'hAA);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
